led_hex_array: RTL and testbench



---
 rtl/led_hex_pkg.sv | 30 +++
 rtl/led_hex_seg.sv | 13 +
 rtl/led_hex_array.sv | 106 ++++++++++
 tb/tb_led_hex_array.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/led_hex_pkg.sv
// led_hex_pkg: shared segment type, blank pattern and active-low hex glyph decode.
package led_hex_pkg;

    typedef logic [6:0] seg_t;

    // Bit 0 = segment a ... bit 6 = segment g; 0 lights the segment.
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t hex_glyph(input logic [3:0] nibble);
        case (nibble)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/led_hex_seg.sv
// led_hex_seg: combinational nibble to active-low seven-segment glyph.
//   nibble  in  4-bit digit value
//   seg     out active-low segments g..a
module led_hex_seg
    import led_hex_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex_glyph(nibble);

endmodule

// File: rtl/led_hex_array.sv
// led_hex_array: multi-digit active-low HEX driver with shadow/active commit, zero blanking and blink.
//   clk, rst_n                   clock, async active-low reset
//   ld_en, ld_value              load whole shadow (digit i at [4i+3:4i])
//   wr_en, wr_digit, wr_nibble   write one shadow digit (index >= DIGITS ignored)
//   commit                       copy updated shadow to active
//   enable, blank_lz, blink_mask display gating controls
//   hex                          registered segments, digit i at [7i+6:7i], 0 = on
//   dirty                        shadow changed since last commit
//   blink_phase                  1 = masked digits currently off
// Optional feature macro: LED_HEX_ARRAY_BLINK_EN builds the blink counter.
module led_hex_array
    import led_hex_pkg::*;
#(
    parameter  int DIGITS    = 4,
    parameter  int BLINK_DIV = 25_000_000,
    localparam int IW        = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_en,
    input  logic [4*DIGITS-1:0]   ld_value,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_digit,
    input  logic [3:0]            wr_nibble,
    input  logic                  commit,
    input  logic                  enable,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  dirty,
    output logic                  blink_phase
);

    logic [4*DIGITS-1:0] shadow, shadow_nxt, active;
    logic [7*DIGITS-1:0] glyphs, hex_nxt;
    logic [DIGITS-1:0]   wr_hit, lz, blink_on;
    logic                zero_run;

    // Index decode doubles as the range check: out-of-range indices hit no digit.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign wr_hit[i] = wr_en && wr_digit == IW'(i);
        led_hex_seg u_seg (
            .nibble (active[4*i +: 4]),
            .seg    (glyphs[7*i +: 7])
        );
        assign hex_nxt[7*i +: 7] = (!enable || lz[i] || blink_on[i]) ? SEG_BLANK : glyphs[7*i +: 7];
    end

    // Load first, then the single-digit write overrides its nibble.
    always_comb begin
        shadow_nxt = ld_en ? ld_value : shadow;
        for (int i = 0; i < DIGITS; i++)
            shadow_nxt[4*i +: 4] = wr_hit[i] ? wr_nibble : shadow_nxt[4*i +: 4];
    end

    // Walk down from the top digit; digit 0 is never a leading zero.
    always_comb begin
        lz       = '0;
        zero_run = blank_lz;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && active[4*i +: 4] == 4'h0;
            lz[i]    = zero_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            hex    <= '1;
            dirty  <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            active <= commit ? shadow_nxt : active;
            hex    <= hex_nxt;
            dirty  <= commit ? 1'b0 : dirty || ld_en || |wr_hit;
        end
    end

`ifdef LED_HEX_ARRAY_BLINK_EN
    localparam int CW = $clog2(BLINK_DIV);

    logic [CW-1:0] blink_cnt;
    logic          wrap;

    assign wrap     = blink_cnt == CW'(BLINK_DIV - 1);
    assign blink_on = blink_mask & {DIGITS{blink_phase}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt   <= wrap ? '0 : blink_cnt + 1'b1;
            blink_phase <= blink_phase ^ wrap;
        end
    end
`else
    logic unused_blink_mask;

    assign unused_blink_mask = ^blink_mask;
    assign blink_on          = '0;
    assign blink_phase       = 1'b0;
`endif

endmodule

// File: tb/tb_led_hex_array.sv
// tb_led_hex_array: directed table-driven bench for led_hex_array (DIGITS=4 and DIGITS=6, BLINK_DIV=4).
module tb_led_hex_array;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G7 = 7'b1111000, G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000, GF = 7'b0001110, B = 7'b1111111;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ld_en = 0, wr_en = 0, commit = 0, enable = 0, blank_lz = 0;
    logic [15:0] ld_value = '0;
    logic [1:0]  wr_digit = '0;
    logic [3:0]  wr_nibble = '0;
    logic [3:0]  blink_mask = '0;
    logic [27:0] hex;
    logic        dirty, blink_phase;

    logic        s_ld_en = 0, s_wr_en = 0, s_commit = 0, s_enable = 0;
    logic [23:0] s_ld_value = '0;
    logic [2:0]  s_wr_digit = '0;
    logic [3:0]  s_wr_nibble = '0;
    logic [5:0]  s_blink_mask = '0;
    logic [41:0] s_hex;
    logic        s_dirty, s_blink_phase;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    led_hex_array #(.DIGITS(4), .BLINK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_value(ld_value), .wr_en(wr_en),
        .wr_digit(wr_digit), .wr_nibble(wr_nibble), .commit(commit), .enable(enable),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .hex(hex), .dirty(dirty),
        .blink_phase(blink_phase)
    );

    led_hex_array #(.DIGITS(6), .BLINK_DIV(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .ld_en(s_ld_en), .ld_value(s_ld_value), .wr_en(s_wr_en),
        .wr_digit(s_wr_digit), .wr_nibble(s_wr_nibble), .commit(s_commit), .enable(s_enable),
        .blank_lz(1'b0), .blink_mask(s_blink_mask), .hex(s_hex), .dirty(s_dirty),
        .blink_phase(s_blink_phase)
    );

    typedef struct {
        logic        ld;
        logic [15:0] ldv;
        logic        wr;
        logic [1:0]  wrd;
        logic [3:0]  wrn;
        logic        cm;
        logic        en;
        logic        blz;
        logic [27:0] hex;
        logic        dirty;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic exp_ph, prev_ph;
        vt[0]  = '{0, 16'h0000, 0, 0, 4'h0, 0, 1, 0, {G0, G0, G0, G0}, 0};
        vt[1]  = '{1, 16'h12AF, 0, 0, 4'h0, 0, 1, 0, {G0, G0, G0, G0}, 1};
        vt[2]  = '{0, 16'h0000, 0, 0, 4'h0, 1, 1, 0, {G0, G0, G0, G0}, 0};
        vt[3]  = '{0, 16'h0000, 0, 0, 4'h0, 0, 1, 0, {G1, G2, GA, GF}, 0};
        vt[4]  = '{1, 16'h0050, 0, 0, 4'h0, 0, 1, 0, {G1, G2, GA, GF}, 1};
        vt[5]  = '{0, 16'h0000, 1, 0, 4'h3, 0, 1, 0, {G1, G2, GA, GF}, 1};
        vt[6]  = '{0, 16'h0000, 0, 0, 4'h0, 1, 1, 1, {G1, G2, GA, GF}, 0};
        vt[7]  = '{0, 16'h0000, 0, 0, 4'h0, 0, 1, 1, {B, B, G5, G3}, 0};
        vt[8]  = '{1, 16'h0050, 0, 0, 4'h0, 1, 1, 1, {B, B, G5, G3}, 0};
        vt[9]  = '{0, 16'h0000, 0, 0, 4'h0, 0, 1, 1, {B, B, G5, G0}, 0};
        vt[10] = '{1, 16'h0000, 0, 0, 4'h0, 1, 1, 1, {B, B, G5, G0}, 0};
        vt[11] = '{0, 16'h0000, 0, 0, 4'h0, 0, 1, 1, {B, B, B, G0}, 0};
        vt[12] = '{0, 16'h0000, 0, 0, 4'h0, 0, 1, 0, {G0, G0, G0, G0}, 0};
        vt[13] = '{1, 16'h0000, 1, 2, 4'h7, 1, 1, 0, {G0, G0, G0, G0}, 0};
        vt[14] = '{0, 16'h0000, 0, 0, 4'h0, 0, 1, 1, {B, G7, G0, G0}, 0};
        vt[15] = '{0, 16'h0000, 0, 0, 4'h0, 0, 0, 1, {B, B, B, B}, 0};
        vt[16] = '{0, 16'h0000, 1, 3, 4'hF, 0, 1, 1, {B, G7, G0, G0}, 1};
        vt[17] = '{0, 16'h0000, 1, 3, 4'h1, 1, 1, 1, {B, G7, G0, G0}, 0};
        vt[18] = '{0, 16'h0000, 0, 0, 4'h0, 0, 1, 1, {G1, G7, G0, G0}, 0};

        // Reset held across edges
        tick();
        tick();
        chk("reset hex", hex, {4{B}});
        chk("reset dirty", dirty, 0);
        chk("reset phase", blink_phase, 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            ld_en = vt[i].ld; ld_value = vt[i].ldv; wr_en = vt[i].wr; wr_digit = vt[i].wrd;
            wr_nibble = vt[i].wrn; commit = vt[i].cm; enable = vt[i].en; blank_lz = vt[i].blz;
            tick();
            chk($sformatf("vec%0d hex", i), hex, vt[i].hex);
            chk($sformatf("vec%0d dirty", i), dirty, vt[i].dirty);
        end

        // Asynchronous reset between edges
        ld_en = 0; wr_en = 0; commit = 0; enable = 1; blank_lz = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("async rst hex", hex, {4{B}});
        chk("async rst dirty", dirty, 0);
        chk("async rst phase", blink_phase, 0);
        tick();
        chk("rst held hex", hex, {4{B}});
        rst_n = 1'b1;

        // Blink sequence from a known counter origin
        ld_en = 1; ld_value = 16'h1234; commit = 1; blink_mask = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            ld_en = 0; commit = 0;
`ifdef LED_HEX_ARRAY_BLINK_EN
            exp_ph  = ((k / 4) % 2) == 1;
            prev_ph = (((k - 1) / 4) % 2) == 1;
`else
            exp_ph  = 1'b0;
            prev_ph = 1'b0;
`endif
            chk($sformatf("blink%0d phase", k), blink_phase, exp_ph);
            if (k == 1)
                chk("blink1 hex", hex, {G0, G0, G0, G0});
            else
                chk($sformatf("blink%0d hex", k), hex, {G1, G2, G3, prev_ph ? B : G4});
        end
        blink_mask = '0;

        // Six-digit build: indices 6 and 7 are out of range
        s_enable = 1; s_wr_en = 1; s_wr_digit = 3'd7; s_wr_nibble = 4'h9;
        tick();
        chk("d6 wr7 dirty", s_dirty, 0);
        s_wr_digit = 3'd6;
        tick();
        chk("d6 wr6 dirty", s_dirty, 0);
        s_wr_en = 0; s_commit = 1;
        tick();
        s_commit = 0;
        tick();
        chk("d6 ignored hex", s_hex, {6{G0}});
        s_wr_en = 1; s_wr_digit = 3'd5;
        tick();
        chk("d6 wr5 dirty", s_dirty, 1);
        s_wr_en = 0; s_commit = 1;
        tick();
        chk("d6 commit dirty", s_dirty, 0);
        s_commit = 0;
        tick();
        chk("d6 wr5 hex", s_hex, {G9, G0, G0, G0, G0, G0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
